mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates the processor's single 16-bit memory port between instruction fetch (IF) and load/store (LS) requesters.
- Sequences each access: grant, memory enable, a fixed read-latency wait, then read-data return.
- One outstanding transaction at a time.
- Sits between the processor datapath (address/data registers) and the synchronous memory that supplies dataFromMem.

Parameters:
- DATA_W, 16: data width of memory and requesters.
- ADDR_W, 16: address width.
- MEM_LAT, 1: memory read latency in cycles from mem_en to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until if_gnt.
- if_addr  in  ADDR_W  IF address; stable while if_req is high.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  IF read data.
- ls_req  in  1  LS request; held until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  LS write data.
- ls_gnt  out  1  one-cycle grant pulse to LS.
- ls_rvalid  out  1  one-cycle pulse; ls_rdata is valid (reads only).
- ls_rdata  out  DATA_W  LS read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE, wait counter cleared, last-winner set to IF.
  - All outputs go to 0, including data and address buses.
  - An in-flight access is dropped; no rvalid is ever issued for it.
  - Leaving reset is synchronous to clk.
- States:
  - IDLE:
    - If no requests, stay in IDLE.
    - If any req is high, pick a winner and latch winner id, we, addr and wdata into registers; go to ACCESS.
    - An IF request always has we=0.
  - ACCESS (exactly 1 cycle):
    - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers.
    - Winner's gnt=1.
    - Write: next state IDLE.
    - Read: load counter with MEM_LAT-1; next state WAIT if MEM_LAT>1, else RESP.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0. mem_en=0.
  - RESP (1 cycle):
    - Winner's rvalid=1; its rdata = mem_rdata registered on entry into RESP.
    - Next state IDLE.
    - No arbitration occurs in RESP.
- Timing:
  - Request seen at cycle 0 in IDLE → gnt and mem_en at cycle 1 → rvalid at cycle 1+MEM_LAT.
  - A write frees the port after 2 cycles.
  - Earliest next gnt is 2 cycles after a read's rvalid.
- Rvalid and rdata:
  - rvalid is only ever asserted for reads, and only to the granted requester.
  - rdata holds its value until the next rvalid to the same requester.
- Requesters:
  - Must hold req, addr, we and wdata stable until gnt.
  - req dropped before gnt is legal; the request is treated as withdrawn.
  - Changes to inputs after the IDLE decision cycle have no effect on the current access.
- Priority (default build): LS wins over IF on simultaneous requests, to avoid stalling the pipeline on a load/store.
- Update last-winner on every grant.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous if_req and ls_req, the requester that did not win the previous grant wins.
  - A single requester always wins immediately.
  - Just after reset, last-winner=IF, so LS wins the first tie.
- Undefined: fixed LS priority; the last-winner register is not compiled in.

Decomposition:
- Package mem_arb_pkg:
  - State enum: IDLE, ACCESS, WAIT, RESP.
  - Requester id constants: REQ_IF=0, REQ_LS=1.
  - MEM_LAT bounds, checked at elaboration; MEM_LAT outside 1..4 is an elaboration error.
- No sub-module. Winner selection is a few gates inside the FSM; splitting it out adds ports without reuse.

Test Plan:
- Reset: hold reset=0 for 3 cycles with if_req=1 → all outputs 0 and busy=0. Release → if_gnt at the 2nd rising edge after release.
- Single IF read, MEM_LAT=1, if_addr=16'h0010, memory returns 16'h00AB → if_gnt+mem_en at cycle 1, if_rvalid with if_rdata=16'h00AB at cycle 2.
- LS write, ls_addr=16'h0020, ls_wdata=16'h1234 → mem_we=1 with that address/data for exactly one cycle; no ls_rvalid; busy low the following cycle.
- Simultaneous if_req and ls_req held for 3 back-to-back grants:
  - Default: LS, LS, LS.
  - With MEM_ARB_ROUND_ROBIN_EN: LS, IF, LS.
- MEM_LAT=3 LS read → ls_rvalid exactly 4 cycles after the request cycle. Assert reset=0 mid-WAIT → no ls_rvalid and state IDLE after release.
- if_addr changed the cycle after the request (during ACCESS) → mem_addr keeps the originally latched address.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arbState_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter side,
// master = datapath/memory side.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the 16-bit memory port: IF vs LS, fixed read latency.
// MEM_ARB_ROUND_ROBIN_EN: alternate winners on ties instead of fixed LS priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : gLatChk
    $error("mem_port_arbiter: MEM_LAT must be within 1..4");
  end

  arbState_e         stateQ, stateD;
  logic [CNT_W-1:0]  cntQ;
  logic              winQ, weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] ifRdataQ, lsRdataQ;
  logic              anyReq, pick;

  assign anyReq = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastWinQ;

  // On a tie the loser of the previous grant goes first.
  always_comb begin
    pick = bus.ls_req ? REQ_LS : REQ_IF;
    if (bus.if_req && bus.ls_req) pick = ~lastWinQ;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        lastWinQ <= REQ_IF;
    else if (stateQ == IDLE && anyReq) lastWinQ <= pick;
  end
`else
  assign pick = bus.ls_req ? REQ_LS : REQ_IF;
`endif

  // Transaction is frozen at the IDLE decision; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winQ   <= REQ_IF;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else if (stateQ == IDLE && anyReq) begin
      winQ   <= pick;
      weQ    <= (pick == REQ_LS) & bus.ls_we;
      addrQ  <= (pick == REQ_LS) ? bus.ls_addr  : bus.if_addr;
      wdataQ <= (pick == REQ_LS) ? bus.ls_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cntQ <= '0;
    else if (stateQ == ACCESS) cntQ <= LAT_M1;
    else if (stateQ == WAIT)   cntQ <= cntQ - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (anyReq) stateD = ACCESS;
      ACCESS:  begin
        if (weQ)              stateD = IDLE;
        else if (MEM_LAT > 1) stateD = WAIT;
        else                  stateD = RESP;
      end
      // The counter reaches zero on this transition.
      WAIT:    if (cntQ <= CNT_W'(1)) stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Read data is sampled on the edge that enters RESP and held until the next return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifRdataQ <= '0;
      lsRdataQ <= '0;
    end else if (stateD == RESP && stateQ != RESP) begin
      if (winQ == REQ_LS) lsRdataQ <= bus.mem_rdata;
      else                ifRdataQ <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (stateQ)
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = weQ;
        bus.mem_addr  = addrQ;
        bus.mem_wdata = wdataQ;
        bus.if_gnt    = (winQ == REQ_IF);
        bus.ls_gnt    = (winQ == REQ_LS);
      end
      RESP: begin
        bus.if_rvalid = (winQ == REQ_IF);
        bus.ls_rvalid = (winQ == REQ_LS);
      end
      default: ;
    endcase
  end

  assign bus.if_rdata = ifRdataQ;
  assign bus.ls_rdata = lsRdataQ;
  assign bus.busy     = (stateQ != IDLE);

endmodule
